wb_data_bridge: RTL

Data-side bus bridge sitting directly downstream of the tenyr core's data port. Accepts single 32-bit load/store requests (strobe, rw, address, write data) and runs each as one Wishbone-classic cycle to external memory or devices. Returns read data with a one-cycle completion pulse and a status code. A programmable watchdog aborts cycles whose slave never acknowledges.

---
 rtl/wb_data_bridge_if.sv | 22 ++
 rtl/wb_data_bridge.sv | 119 +++++++++++
 2 files changed

// File: rtl/wb_data_bridge_if.sv
// rtl/wb_data_bridge_if.sv - Wishbone-classic data bus between the bridge and external memory/devices.
interface wb_data_bridge_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_data_bridge.sv
// rtl/wb_data_bridge.sv - Runs single core load/store requests as Wishbone-classic cycles with a watchdog.
module wb_data_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                strobe,
  input  logic                rw,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                busy,
  output logic                done,
  output logic [31:0]         rdata,
  output logic [1:0]          status,
  wb_data_bridge_if.master    wb
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          WDOG_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUS_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic {IDLE, BUS} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    status_q, status_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      rdata_q  <= '0;
      status_q <= ST_OK;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        // Bus responses arriving here are late or spurious and are dropped.
        if (strobe) begin
          we_d     = rw;
          adr_d    = addr;
          dat_d    = wdata;
          status_d = ST_OK;
          cnt_d    = '0;
          state_d  = BUS;
        end
      end
      BUS: begin
        if (wb.wb_err_i) begin
          status_d = ST_BUS_ERR;
          if (!we_q) rdata_d = '0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wb.wb_ack_i) begin
          status_d = ST_OK;
          if (!we_q) rdata_d = wb.wb_dat_i;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          status_d = ST_TIMEOUT;
          if (!we_q) rdata_d = '0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == BUS);
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign status      = status_q;
  assign wb.wb_cyc_o = (state_q == BUS);
  assign wb.wb_stb_o = (state_q == BUS);
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = 4'hF;

endmodule
